// File: rtl/sipo_rx_pkg.sv
// sipo_rx_pkg
// Shared definitions for the parametrised UART receive front end:
//   - rx_state_e : receiver FSM states
//   - PAR_*      : parity-mode encodings as seen on cfg_parity
//   - maj3()     : majority-of-3 vote used for bit decisions
package sipo_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    // cfg_parity encoding 2'b11 is treated as "none" as well.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler
// Line conditioning and bit timing for the receiver.
//   baud_clk  in : oversampling clock
//   rst       in : synchronous active-high reset
//   data_tx   in : asynchronous serial line (idle high)
//   run       in : FSM is inside a frame; holds cnt at 0 when low
//   start_det out: armed and synchronised line low (start-bit candidate)
//   bit_val   out: majority vote of the three mid-bit samples
//   bit_done  out: strobe during the cycle in which bit_val is decided
module rx_bit_sampler
    import sipo_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic baud_clk,
    input  logic rst,
    input  logic data_tx,
    input  logic run,
    output logic start_det,
    output logic bit_val,
    output logic bit_done
);

    localparam int H  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [1:0]    fill_q, fill_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s0_q, s0_d;
    logic          s1_q, s1_d;

    always_comb begin
        sync1_d = data_tx;
        sync2_d = sync1_q;
        // The synchroniser resets to 1, so its output only reflects the real
        // line after two edges; arming waits for that so a line held low
        // through reset cannot look like a high-then-low transition.
        fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
        armed_d = armed_q | ((fill_q == 2'd2) & sync2_q);

        if (!run || cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        s0_d = (run && cnt_q == CNT_S0) ? sync2_q : s0_q;
        s1_d = (run && cnt_q == CNT_S1) ? sync2_q : s1_q;
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge baud_clk) begin
        s0_q <= s0_d;
        s1_q <= s1_d;
    end

    // Third sample is the live synchronised line at cnt = H+1.
    assign bit_val   = maj3(s0_q, s1_q, sync2_q);
    assign bit_done  = run && (cnt_q == CNT_VOTE);
    assign start_det = armed_q & ~sync2_q;

endmodule

// File: rtl/sipo_rx_param.sv
// sipo_rx_param
// Parametrised serial-to-parallel UART receiver with one-deep output buffer.
//   baud_clk    in : oversampling clock (OVERSAMPLE cycles per bit)
//   rst         in : synchronous active-high reset
//   data_tx     in : asynchronous serial line, idle high
//   cfg_parity  in : 00 none, 01 even, 10 odd, 11 none; latched at start
//   rx_ready    in : consumer accepts rx_data this cycle
//   rx_valid    out: buffer holds an unconsumed frame
//   rx_data     out: payload, LSB = first bit on the line
//   parity_err  out: parity violation (qualified by rx_valid)
//   frame_err   out: a stop bit voted 0 (qualified by rx_valid)
//   break_det   out: data, parity and first stop all 0 (qualified by rx_valid)
//   overrun_err out: one-cycle pulse when a completed frame is dropped
//   active_flag out: FSM is inside a frame
module sipo_rx_param
    import sipo_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 data_tx,
    input  logic [1:0]           cfg_parity,
    input  logic                 rx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 active_flag
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    logic start_det, bit_val, bit_done;

    rx_state_e            state_q, state_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [1:0]           mode_q, mode_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_o_q, perr_o_d;
    logic                 ferr_o_q, ferr_o_d;
    logic                 brk_o_q, brk_o_d;
    logic                 ovr_q, ovr_d;
    logic                 par_on;
    logic                 frame_done;

    rx_bit_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .baud_clk (baud_clk),
        .rst      (rst),
        .data_tx  (data_tx),
        .run      (state_q != ST_IDLE),
        .start_det(start_det),
        .bit_val  (bit_val),
        .bit_done (bit_done)
    );

    assign par_on = (mode_q == PAR_EVEN) || (mode_q == PAR_ODD);

    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        mode_d     = mode_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        valid_d    = valid_q;
        data_d     = data_q;
        perr_o_d   = perr_o_q;
        ferr_o_d   = ferr_o_q;
        brk_o_d    = brk_o_q;
        ovr_d      = 1'b0;
        frame_done = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d   = ST_START;
                    bit_idx_d = '0;
                    mode_d    = (cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD)
                                ? cfg_parity : PAR_NONE;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    brk_d     = 1'b0;
                end
            end
            ST_START: begin
                // A high vote means the low level was a glitch.
                if (bit_done) begin
                    state_d = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        state_d   = par_on ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    par_bit_d = bit_val;
                    // Even mode wants XOR 0, odd mode wants XOR 1.
                    perr_d    = ((^shift_q) ^ bit_val) != (mode_q == PAR_ODD);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    ferr_d = ferr_q | ~bit_val;
                    if (bit_idx_q == 4'd0) begin
                        brk_d = (shift_q == '0) && !(par_on && par_bit_q) && !bit_val;
                    end
                    if (bit_idx_q == LAST_STOP) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A consume in the same cycle frees the buffer for the new frame.
        if (frame_done) begin
            if (!valid_q || rx_ready) begin
                valid_d  = 1'b1;
                data_d   = shift_q;
                perr_o_d = perr_d;
                ferr_o_d = ferr_d;
                brk_o_d  = brk_d;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            mode_q    <= PAR_NONE;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            perr_o_q  <= 1'b0;
            ferr_o_q  <= 1'b0;
            brk_o_q   <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            mode_q    <= mode_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            perr_o_q  <= perr_o_d;
            ferr_o_q  <= ferr_o_d;
            brk_o_q   <= brk_o_d;
            ovr_q     <= ovr_d;
        end
    end

    always_ff @(posedge baud_clk) begin
        shift_q   <= shift_d;
        par_bit_q <= par_bit_d;
    end

    assign rx_valid    = valid_q;
    assign rx_data     = data_q;
    assign parity_err  = perr_o_q;
    assign frame_err   = ferr_o_q;
    assign break_det   = brk_o_q;
    assign overrun_err = ovr_q;
    assign active_flag = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_rx_param.sv
// Testbench for sipo_rx_param: default configuration (A) and a 7-bit,
// 8x oversampled, 2-stop-bit configuration (B), driven with random frames
// and compared against a frame-level reference model.
module tb_sipo_rx_param;

    localparam int OS_A = 16;
    localparam int OS_B = 8;
    localparam int ND_A = 8;
    localparam int ND_B = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, data_a, rdy_a, val_a, pe_a, fe_a, bk_a, ov_a, act_a;
    logic [1:0] cfg_a;
    logic [7:0] dat_a;
    logic       rst_b, data_b, rdy_b, val_b, pe_b, fe_b, bk_b, ov_b, act_b;
    logic [1:0] cfg_b;
    logic [6:0] dat_b;

    sipo_rx_param dut_a (
        .baud_clk(clk), .rst(rst_a), .data_tx(data_a), .cfg_parity(cfg_a),
        .rx_ready(rdy_a), .rx_valid(val_a), .rx_data(dat_a), .parity_err(pe_a),
        .frame_err(fe_a), .break_det(bk_a), .overrun_err(ov_a), .active_flag(act_a)
    );

    sipo_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .STOP_BITS(2)) dut_b (
        .baud_clk(clk), .rst(rst_b), .data_tx(data_b), .cfg_parity(cfg_b),
        .rx_ready(rdy_b), .rx_valid(val_b), .rx_data(dat_b), .parity_err(pe_b),
        .frame_err(fe_b), .break_det(bk_b), .overrun_err(ov_b), .active_flag(act_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [8:0] d;
        logic       p;
        logic       f;
        logic       b;
    } cap_t;

    cap_t cap_a[$];
    cap_t cap_b[$];
    int   cyc = 0;
    int   t_act_a = 0, lat_a = 0, rise_a = 0, ovr_a = 0;
    int   t_act_b = 0, lat_b = 0, rise_b = 0, ovr_b = 0;
    logic pa_a = 1'b0, pv_a = 1'b0, pa_b = 1'b0, pv_b = 1'b0;

    // Mid-cycle observer: records transfers, start-of-frame and valid-rise times.
    always @(negedge clk) begin
        cap_t c;
        cyc++;
        if (act_a && !pa_a) begin t_act_a = cyc; rise_a++; end
        if (val_a && !pv_a) lat_a = cyc - t_act_a;
        if (val_a && rdy_a) begin
            c.d = 9'(dat_a); c.p = pe_a; c.f = fe_a; c.b = bk_a;
            cap_a.push_back(c);
        end
        if (ov_a) ovr_a++;
        pa_a = act_a; pv_a = val_a;
        if (act_b && !pa_b) begin t_act_b = cyc; rise_b++; end
        if (val_b && !pv_b) lat_b = cyc - t_act_b;
        if (val_b && rdy_b) begin
            c.d = 9'(dat_b); c.p = pe_b; c.f = fe_b; c.b = bk_b;
            cap_b.push_back(c);
        end
        if (ov_b) ovr_b++;
        pa_b = act_b; pv_b = val_b;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line-level frame: start 0, data LSB first, optional parity, stop bits.
    task automatic build_frame(input bit sb, input logic [8:0] d, input logic [1:0] mode,
                               input bit flip, input bit st0, input bit st1,
                               output logic [15:0] fr, output int n);
        int nd = sb ? ND_B : ND_A;
        int ones;
        bit par, pbit;
        ones = 0;
        for (int i = 0; i < nd; i++) ones += int'(d[i]);
        par  = (mode == 2'd1) || (mode == 2'd2);
        pbit = ((ones % 2) == 1) ^ (mode == 2'd2) ^ flip;
        fr = '1;
        fr[0] = 1'b0;
        n = 1;
        for (int i = 0; i < nd; i++) begin fr[n] = d[i]; n++; end
        if (par) begin fr[n] = pbit; n++; end
        fr[n] = !st0; n++;
        if (sb) begin fr[n] = !st1; n++; end
    endtask

    task automatic send(input bit sb, input logic [15:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            if (sb) data_b = fr[i]; else data_a = fr[i];
            tick(sb ? OS_B : OS_A);
        end
        if (sb) data_b = 1'b1; else data_a = 1'b1;
    endtask

    // Sends one frame with rx_ready high and compares against the model.
    task automatic run_frame(input string tag, input bit sb, input logic [8:0] d_in,
                             input logic [1:0] mode, input bit flip, input bit st0, input bit st1);
        int nd = sb ? ND_B : ND_A;
        int os = sb ? OS_B : OS_A;
        logic [8:0] d;
        logic [15:0] fr;
        int n, ones, got_n, glat, exp_lat;
        bit par, pbit, vnow;
        cap_t e, g;
        d = d_in & 9'((1 << nd) - 1);
        build_frame(sb, d, mode, flip, st0, st1, fr, n);
        if (sb) cfg_b = mode; else cfg_a = mode;
        send(sb, fr, n);
        tick(2 * os);
        ones = $countones(d);
        par  = (mode == 2'd1) || (mode == 2'd2);
        pbit = par ? fr[1 + nd] : 1'b0;
        e.d = d;
        e.p = par && ((((ones + int'(pbit)) % 2) == 1) != (mode == 2'd2));
        e.f = st0 | (sb & st1);
        e.b = (d == 9'd0) && !(par && pbit) && st0;
        exp_lat = (n - 1) * os + os / 2 + 2;
        g = '0;
        if (sb) begin
            got_n = cap_b.size(); if (got_n > 0) g = cap_b.pop_front();
            glat = lat_b; vnow = val_b; cap_b.delete();
        end else begin
            got_n = cap_a.size(); if (got_n > 0) g = cap_a.pop_front();
            glat = lat_a; vnow = val_a; cap_a.delete();
        end
        check({tag, "_count"}, got_n, 1);
        check({tag, "_data"}, g.d, e.d);
        check({tag, "_perr"}, g.p, e.p);
        check({tag, "_ferr"}, g.f, e.f);
        check({tag, "_brk"}, g.b, e.b);
        check({tag, "_latency"}, glat, exp_lat);
        check({tag, "_valid_drop"}, vnow, 0);
    endtask

    initial begin
        logic [15:0] fr;
        int n, r0, o0;
        cap_t g;
        rst_a = 1; rst_b = 1; data_a = 1; data_b = 1;
        rdy_a = 1; rdy_b = 1; cfg_a = 0; cfg_b = 0;
        tick(3);
        check("rst_valid_a", val_a, 0);
        check("rst_data_a", dat_a, 0);
        check("rst_perr_a", pe_a, 0);
        check("rst_ferr_a", fe_a, 0);
        check("rst_brk_a", bk_a, 0);
        check("rst_ovr_a", ov_a, 0);
        check("rst_active_a", act_a, 0);
        check("rst_valid_b", val_b, 0);
        check("rst_active_b", act_b, 0);
        rst_a = 0; rst_b = 0;
        tick(10);

        run_frame("a5_even", 0, 9'h0A5, 2'd1, 0, 0, 0);
        run_frame("3c_odd_badpar", 0, 9'h03C, 2'd2, 1, 0, 0);
        run_frame("stop0", 0, 9'h03C, 2'd0, 0, 1, 0);
        run_frame("break", 0, 9'h000, 2'd0, 0, 1, 0);
        run_frame("break_par", 0, 9'h000, 2'd1, 0, 1, 0);
        run_frame("mode11", 0, 9'h0C3, 2'd3, 0, 0, 0);

        // Short low glitch: enters START, votes high, no frame.
        r0 = rise_a;
        data_a = 0; tick(6); data_a = 1; tick(20);
        check("glitch_started", rise_a - r0, 1);
        check("glitch_idle", act_a, 0);
        check("glitch_noframe", cap_a.size(), 0);
        cap_a.delete();

        // Overrun: second frame dropped while first is held.
        rdy_a = 0; cfg_a = 0;
        build_frame(0, 9'h011, 2'd0, 0, 0, 0, fr, n);
        send(0, fr, n); tick(2 * OS_A);
        check("ovr_first_valid", val_a, 1);
        check("ovr_first_data", dat_a, 8'h11);
        o0 = ovr_a;
        build_frame(0, 9'h022, 2'd0, 0, 0, 0, fr, n);
        send(0, fr, n); tick(2 * OS_A);
        check("ovr_pulses", ovr_a - o0, 1);
        check("ovr_held_data", dat_a, 8'h11);
        check("ovr_held_valid", val_a, 1);
        rdy_a = 1; tick(3);
        check("ovr_consume_count", cap_a.size(), 1);
        g = '0;
        if (cap_a.size() > 0) g = cap_a.pop_front();
        check("ovr_consume_data", g.d, 9'h011);
        check("ovr_valid_drop", val_a, 0);
        cap_a.delete();

        // Line low through reset: no start until high then low.
        data_a = 0; rst_a = 1; tick(2); rst_a = 0;
        r0 = rise_a;
        tick(3 * OS_A);
        check("lowrst_nostart", rise_a - r0, 0);
        check("lowrst_active", act_a, 0);
        data_a = 1; tick(OS_A);
        run_frame("after_low", 0, 9'h05A, 2'd0, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            run_frame("rnd_a", 0, 9'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), 0);
        end

        run_frame("b55", 1, 9'h055, 2'd0, 0, 0, 0);
        run_frame("b_stop2_zero", 1, 9'h013, 2'd1, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            run_frame("rnd_b", 1, 9'($urandom_range(0, 127)), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 5) == 0));
        end

        // Reset during a frame with a held frame in the buffer.
        rdy_b = 0; cfg_b = 0;
        build_frame(1, 9'h02A, 2'd0, 0, 0, 0, fr, n);
        send(1, fr, n); tick(2 * OS_B);
        check("b_held_valid", val_b, 1);
        build_frame(1, 9'h07F, 2'd0, 0, 0, 0, fr, n);
        fork
            send(1, fr, n);
            begin
                for (int i = 0; i < 200 && !act_b; i++) tick(1);
                check("b_rst_started", act_b, 1);
                tick(30);
                rst_b = 1; tick(1);
                check("b_rst_valid", val_b, 0);
                check("b_rst_data", dat_b, 0);
                check("b_rst_active", act_b, 0);
                check("b_rst_flags", {pe_b, fe_b, bk_b, ov_b}, 0);
                rst_b = 0;
            end
        join
        tick(2 * OS_B);
        rdy_b = 1; tick(3);
        check("b_rst_noframe", cap_b.size(), 0);
        check("b_rst_still_idle", val_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
